// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types and constants for the ID/EX stage.
// Instruction field positions, FSM states, control bubble value.
package id_ex_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam int INST_W  = 32;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  // Control bundle value for a bubble (no writes, no memory op).
  localparam logic [63:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: decode-side and EX-side bundle of the ID/EX stage.
// master = decode/EX environment, slave = the stage itself.
interface id_ex_pipe_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
);
  logic              id_valid_i;
  logic              id_ready_o;
  logic [31:0]       id_inst_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [XLEN-1:0]   id_pc4_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic              id_is_load_i;
  logic              wb_we_i;
  logic [4:0]        wb_rd_i;
  logic [XLEN-1:0]   wb_data_i;
  logic              flush_i;
  logic              ex_ready_i;
  logic              ex_valid_o;
  logic [31:0]       ex_inst_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_pc4_o;
  logic [XLEN-1:0]   ex_rs1_o;
  logic [XLEN-1:0]   ex_rs2_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [4:0]        ex_rd_o;
  logic              ex_is_load_o;

  modport master (
    output id_valid_i, id_inst_i, id_pc_i, id_pc4_i,
    output id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output id_ctrl_i, id_rs1_used_i, id_rs2_used_i,
    output id_is_load_i, wb_we_i, wb_rd_i, wb_data_i,
    output flush_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_inst_o, ex_pc_o,
    input  ex_pc4_o, ex_rs1_o, ex_rs2_o, ex_imm_o,
    input  ex_ctrl_o, ex_rd_o, ex_is_load_o
  );

  modport slave (
    input  id_valid_i, id_inst_i, id_pc_i, id_pc4_i,
    input  id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  id_ctrl_i, id_rs1_used_i, id_rs2_used_i,
    input  id_is_load_i, wb_we_i, wb_rd_i, wb_data_i,
    input  flush_i, ex_ready_i,
    output id_ready_o, ex_valid_o, ex_inst_o, ex_pc_o,
    output ex_pc4_o, ex_rs1_o, ex_rs2_o, ex_imm_o,
    output ex_ctrl_o, ex_rd_o, ex_is_load_o
  );
endinterface

// File: rtl/id_ex_hazard_det.sv
// id_ex_hazard_det: combinational load-use hazard compare.
// Flags a decode consumer of a load destination still in EX.
module id_ex_hazard_det (
  input  logic       id_valid_i,
  input  logic       ex_valid_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  output logic       hazard_o
);
  logic m1;
  logic m2;

  assign m1 = rs1_used_i & (rs1_i == ex_rd_i);
  assign m2 = rs2_used_i & (rs2_i == ex_rd_i);

  assign hazard_o = id_valid_i & ex_valid_i & ex_is_load_i
                  & (ex_rd_i != 5'd0) & (m1 | m2);
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX register with handshake, load-use stall, flush.
// Optional writeback bypass on capture: define WB_BYPASS_EN.
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int CTRL_W            = 12,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  id_ex_pipe_if.slave      bus,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int BCW = (LOAD_STALL_CYCLES > 1)
                     ? $clog2(LOAD_STALL_CYCLES) : 1;
  localparam logic [BCW-1:0] BCNT_LOAD =
    BCW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CTRL_W-1:0] CTRL_NOP =
    CTRL_BUBBLE[CTRL_W-1:0];

  state_e            state_q, state_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]        rd_q, rd_d;
  logic              ld_q, ld_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic       advance;
  logic       hazard;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rs1_idx = bus.id_inst_i[RS1_MSB:RS1_LSB];
  assign rs2_idx = bus.id_inst_i[RS2_MSB:RS2_LSB];
  assign advance = ~valid_q | bus.ex_ready_i;

  id_ex_hazard_det u_haz (
    .id_valid_i   (bus.id_valid_i),
    .ex_valid_i   (valid_q),
    .ex_is_load_i (ld_q),
    .ex_rd_i      (rd_q),
    .rs1_i        (rs1_idx),
    .rs2_i        (rs2_idx),
    .rs1_used_i   (bus.id_rs1_used_i),
    .rs2_used_i   (bus.id_rs2_used_i),
    .hazard_o     (hazard)
  );

`ifdef WB_BYPASS_EN
  // Regfile reads before it writes, so take the in-flight WB value.
  logic byp1;
  logic byp2;
  assign byp1 = bus.wb_we_i & (bus.wb_rd_i != 5'd0)
              & (bus.wb_rd_i == rs1_idx);
  assign byp2 = bus.wb_we_i & (bus.wb_rd_i != 5'd0)
              & (bus.wb_rd_i == rs2_idx);
  assign op1 = byp1 ? bus.wb_data_i : bus.id_rs1_data_i;
  assign op2 = byp2 ? bus.wb_data_i : bus.id_rs2_data_i;
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_we_i, bus.wb_rd_i, bus.wb_data_i};
  assign op1 = bus.id_rs1_data_i;
  assign op2 = bus.id_rs2_data_i;
`endif

  assign bus.id_ready_o = advance & (state_q == ST_RUN)
                        & ~hazard & ~bus.flush_i;

  // Next state: hold unless EX can take a new entry.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    ld_d    = ld_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (advance) begin
      valid_d = 1'b0;
      inst_d  = '0;
      pc_d    = '0;
      pc4_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      imm_d   = '0;
      ctrl_d  = CTRL_NOP;
      rd_d    = '0;
      ld_d    = 1'b0;
      if (bus.flush_i) begin
        state_d = ST_RUN;
        bcnt_d  = '0;
        if (~&flush_q) flush_d = flush_q + CNT_W'(1);
      end else if (state_q == ST_STALL) begin
        bcnt_d = bcnt_q - BCW'(1);
        if (bcnt_q == BCW'(1)) state_d = ST_RUN;
        if (~&stall_q) stall_d = stall_q + CNT_W'(1);
      end else if (hazard) begin
        if (~&stall_q) stall_d = stall_q + CNT_W'(1);
        if (LOAD_STALL_CYCLES > 1) begin
          bcnt_d  = BCNT_LOAD;
          state_d = ST_STALL;
        end
      end else if (bus.id_valid_i) begin
        valid_d = 1'b1;
        inst_d  = bus.id_inst_i;
        pc_d    = bus.id_pc_i;
        pc4_d   = bus.id_pc4_i;
        rs1_d   = op1;
        rs2_d   = op2;
        imm_d   = bus.id_imm_i;
        ctrl_d  = bus.id_ctrl_i;
        rd_d    = bus.id_inst_i[RD_MSB:RD_LSB];
        ld_d    = bus.id_is_load_i;
      end
    end
  end

  // State, payload and counters; reset empties EX and returns to RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      bcnt_q  <= '0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      ld_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.ex_valid_o   = valid_q;
  assign bus.ex_inst_o    = inst_q;
  assign bus.ex_pc_o      = pc_q;
  assign bus.ex_pc4_o     = pc4_q;
  assign bus.ex_rs1_o     = rs1_q;
  assign bus.ex_rs2_o     = rs2_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_ctrl_o    = ctrl_q;
  assign bus.ex_rd_o      = rd_q;
  assign bus.ex_is_load_o = ld_q;
  assign stall_cnt_o      = stall_q;
  assign flush_cnt_o      = flush_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed bench for id_ex_pipe.
// Three builds: 1 bubble, 3 bubbles, 1 bubble with 2-bit counters.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] pc = 32'h100;
  logic [31:0] pc4 = 32'h104;
  logic [31:0] r1d = 32'h11;
  logic [31:0] r2d = 32'h22;
  logic [31:0] imm = 32'h33;
  logic [11:0] ctrl = 12'hABC;
  logic        r1u = 1'b0;
  logic        r2u = 1'b0;
  logic        ld = 1'b0;
  logic        wbwe = 1'b0;
  logic [4:0]  wbrd = '0;
  logic [31:0] wbdata = '0;
  logic        flush = 1'b0;
  logic        exrdy = 1'b1;

  logic [15:0] sc1, fc1, sc3, fc3;
  logic [1:0]  scs, fcs;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h11111111;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_if #(.XLEN(32), .CTRL_W(12)) bus1 ();
  id_ex_pipe_if #(.XLEN(32), .CTRL_W(12)) bus3 ();
  id_ex_pipe_if #(.XLEN(32), .CTRL_W(12)) buss ();

  assign bus1.id_valid_i = valid;
  assign bus1.id_inst_i = inst;
  assign bus1.id_pc_i = pc;
  assign bus1.id_pc4_i = pc4;
  assign bus1.id_rs1_data_i = r1d;
  assign bus1.id_rs2_data_i = r2d;
  assign bus1.id_imm_i = imm;
  assign bus1.id_ctrl_i = ctrl;
  assign bus1.id_rs1_used_i = r1u;
  assign bus1.id_rs2_used_i = r2u;
  assign bus1.id_is_load_i = ld;
  assign bus1.wb_we_i = wbwe;
  assign bus1.wb_rd_i = wbrd;
  assign bus1.wb_data_i = wbdata;
  assign bus1.flush_i = flush;
  assign bus1.ex_ready_i = exrdy;

  assign bus3.id_valid_i = valid;
  assign bus3.id_inst_i = inst;
  assign bus3.id_pc_i = pc;
  assign bus3.id_pc4_i = pc4;
  assign bus3.id_rs1_data_i = r1d;
  assign bus3.id_rs2_data_i = r2d;
  assign bus3.id_imm_i = imm;
  assign bus3.id_ctrl_i = ctrl;
  assign bus3.id_rs1_used_i = r1u;
  assign bus3.id_rs2_used_i = r2u;
  assign bus3.id_is_load_i = ld;
  assign bus3.wb_we_i = wbwe;
  assign bus3.wb_rd_i = wbrd;
  assign bus3.wb_data_i = wbdata;
  assign bus3.flush_i = flush;
  assign bus3.ex_ready_i = exrdy;

  assign buss.id_valid_i = valid;
  assign buss.id_inst_i = inst;
  assign buss.id_pc_i = pc;
  assign buss.id_pc4_i = pc4;
  assign buss.id_rs1_data_i = r1d;
  assign buss.id_rs2_data_i = r2d;
  assign buss.id_imm_i = imm;
  assign buss.id_ctrl_i = ctrl;
  assign buss.id_rs1_used_i = r1u;
  assign buss.id_rs2_used_i = r2u;
  assign buss.id_is_load_i = ld;
  assign buss.wb_we_i = wbwe;
  assign buss.wb_rd_i = wbrd;
  assign buss.wb_data_i = wbdata;
  assign buss.flush_i = flush;
  assign buss.ex_ready_i = exrdy;

  id_ex_pipe #(
    .XLEN(32), .CTRL_W(12),
    .LOAD_STALL_CYCLES(1), .CNT_W(16)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  id_ex_pipe #(
    .XLEN(32), .CTRL_W(12),
    .LOAD_STALL_CYCLES(3), .CNT_W(16)
  ) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3)
  );

  id_ex_pipe #(
    .XLEN(32), .CTRL_W(12),
    .LOAD_STALL_CYCLES(1), .CNT_W(2)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .bus(buss),
    .stall_cnt_o(scs), .flush_cnt_o(fcs)
  );

  function automatic logic [31:0] mk(
    input logic [4:0] rd, rs1, rs2
  );
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic v, input logic [31:0] in,
    input logic u1, input logic u2, input logic l
  );
    valid = v;
    inst  = in;
    r1u   = u1;
    r2u   = u2;
    ld    = l;
  endtask

  task automatic reset_all();
    flush = 1'b0;
    exrdy = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_valid", bus1.ex_valid_o, 0);
    chk("rst_stall", sc1, 0);
    chk("rst_flush", fc1, 0);
    chk("rst_ctrl", bus1.ex_ctrl_o, 0);
    rst = 1'b0;
    drive(1'b1, mk(3, 1, 2), 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_ready", bus1.id_ready_o, 1);

    // basic capture
    tick();
    chk("cap_valid", bus1.ex_valid_o, 1);
    chk("cap_inst", bus1.ex_inst_o, mk(3, 1, 2));
    chk("cap_rd", bus1.ex_rd_o, 3);
    chk("cap_pc", bus1.ex_pc_o, 32'h100);
    chk("cap_pc4", bus1.ex_pc4_o, 32'h104);
    chk("cap_rs1", bus1.ex_rs1_o, 32'h11);
    chk("cap_rs2", bus1.ex_rs2_o, 32'h22);
    chk("cap_imm", bus1.ex_imm_o, 32'h33);
    chk("cap_ctrl", bus1.ex_ctrl_o, 12'hABC);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bub_valid", bus1.ex_valid_o, 0);
    chk("bub_ctrl", bus1.ex_ctrl_o, 0);
    chk("bub_inst", bus1.ex_inst_o, 0);

    // load-use, 1 and 3 bubbles
    reset_all();
    drive(1'b1, mk(5, 1, 0), 1'b1, 1'b0, 1'b1);
    tick();
    chk("lw_load", bus1.ex_is_load_o, 1);
    drive(1'b1, mk(6, 5, 1), 1'b1, 1'b1, 1'b0);
    #1;
    chk("lu_ready0", bus1.id_ready_o, 0);
    tick();
    chk("lu1_bub", bus1.ex_valid_o, 0);
    chk("lu1_stall", sc1, 1);
    chk("lu1_ready", bus1.id_ready_o, 1);
    chk("lu3_bub1", bus3.ex_valid_o, 0);
    chk("lu3_ready", bus3.id_ready_o, 0);
    tick();
    chk("lu1_valid", bus1.ex_valid_o, 1);
    chk("lu1_rd", bus1.ex_rd_o, 6);
    chk("lu3_bub2", bus3.ex_valid_o, 0);
    tick();
    chk("lu3_bub3", bus3.ex_valid_o, 0);
    chk("lu3_stall", sc3, 3);
    tick();
    chk("lu3_valid", bus3.ex_valid_o, 1);
    chk("lu3_rd", bus3.ex_rd_o, 6);
    chk("lu1_stall_hold", sc1, 1);

    // no false hazard: x0 and unused rs2
    drive(1'b1, mk(0, 1, 0), 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, mk(6, 0, 0), 1'b1, 1'b1, 1'b0);
    #1;
    chk("x0_ready", bus1.id_ready_o, 1);
    tick();
    chk("x0_valid", bus1.ex_valid_o, 1);
    drive(1'b1, mk(5, 1, 0), 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, mk(9, 1, 5), 1'b1, 1'b0, 1'b0);
    #1;
    chk("rs2u_ready", bus1.id_ready_o, 1);
    tick();
    chk("rs2u_valid", bus1.ex_valid_o, 1);
    chk("rs2u_rd", bus1.ex_rd_o, 9);
    chk("rs2u_stall", sc1, 1);

    // backpressure, with a flush that must not squash EX
    exrdy = 1'b0;
    flush = 1'b1;
    drive(1'b1, mk(7, 2, 3), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", bus1.id_ready_o, 0);
      tick();
      chk("bp_valid", bus1.ex_valid_o, 1);
      chk("bp_rd", bus1.ex_rd_o, 9);
      chk("bp_stall", sc1, 1);
      chk("bp_flush", fc1, 0);
    end
    exrdy = 1'b1;
    flush = 1'b0;
    #1;
    chk("bp_rel_ready", bus1.id_ready_o, 1);
    tick();
    chk("bp_rel_rd", bus1.ex_rd_o, 7);
    chk("bp_rel_flush", fc1, 0);

    // flush and hazard together: only flush counts
    reset_all();
    drive(1'b1, mk(5, 1, 0), 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, mk(6, 5, 1), 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fh_ready", bus1.id_ready_o, 0);
    tick();
    chk("fh_valid", bus1.ex_valid_o, 0);
    chk("fh_flush", fc1, 1);
    chk("fh_stall", sc1, 0);
    flush = 1'b0;

    // flush during STALL
    reset_all();
    drive(1'b1, mk(5, 1, 0), 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, mk(6, 5, 1), 1'b1, 1'b1, 1'b0);
    tick();
    chk("fs_stall0", sc3, 1);
    flush = 1'b1;
    tick();
    chk("fs_valid", bus3.ex_valid_o, 0);
    chk("fs_flush", fc3, 1);
    chk("fs_stall", sc3, 1);
    flush = 1'b0;
    #1;
    chk("fs_ready", bus3.id_ready_o, 1);
    tick();
    chk("fs_cap", bus3.ex_valid_o, 1);

    // reset mid-stream and mid-STALL
    reset_all();
    drive(1'b1, mk(5, 1, 0), 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, mk(6, 5, 1), 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk("ms_pre", bus1.ex_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("ms_valid", bus1.ex_valid_o, 0);
    chk("ms_rd", bus1.ex_rd_o, 0);
    chk("ms_pc", bus1.ex_pc_o, 0);
    chk("ms_stall", sc1, 0);
    rst = 1'b0;
    #1;
    chk("ms_ready1", bus1.id_ready_o, 1);
    chk("ms_ready3", bus3.id_ready_o, 1);
    tick();
    chk("ms_cap3", bus3.ex_valid_o, 1);

    // writeback bypass
    reset_all();
    wbwe = 1'b1;
    wbrd = 5'd7;
    wbdata = 32'hDEADBEEF;
    r1d = 32'h11111111;
    r2d = 32'h22222222;
    drive(1'b1, mk(3, 7, 2), 1'b1, 1'b1, 1'b0);
    tick();
    chk("byp_rs1", bus1.ex_rs1_o, BYP_EXP);
    chk("byp_rs2_stale", bus1.ex_rs2_o, 32'h22222222);
    wbrd = 5'd0;
    drive(1'b1, mk(3, 0, 2), 1'b1, 1'b1, 1'b0);
    tick();
    chk("byp_x0", bus1.ex_rs1_o, 32'h11111111);
    wbwe = 1'b0;
    wbrd = 5'd7;
    drive(1'b1, mk(3, 7, 2), 1'b1, 1'b1, 1'b0);
    tick();
    chk("byp_we0", bus1.ex_rs1_o, 32'h11111111);
    wbrd = 5'd0;
    wbdata = '0;

    // counter saturation with 2-bit counters
    reset_all();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, mk(5, 1, 0), 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, mk(6, 5, 1), 1'b1, 1'b1, 1'b0);
      tick();
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat_stall", scs, 3);
    chk("sat_wide", sc1, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised decode-to-execute pipeline stage: successor to the fixed-width ID/EX register, with valid/ready handshake, load-use hazard detection with configurable bubble count, flush, saturating stall/flush counters, and an optional writeback-to-decode operand bypass. It sits between the decode logic (regfile, imm_gen, ctrl_unit outputs) and EX, and replaces the bare enable/reset register.

## Interface
Parameters:
- XLEN, 32, datapath width (pc, operands, imm)
- CTRL_W, 12, width of packed control bundle (AluSel/BSel/ASel/MemRW/WBSel/BrUn/RegWEn)
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (≥1)
- CNT_W, 16, width of performance counters

Ports: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- id_valid_i  in  1  decode holds a valid instruction
- id_ready_o  out  1  stage accepts decode this cycle
- id_inst_i  in  32  instruction (rd=[11:7], rs1=[19:15], rs2=[24:20])
- id_pc_i, id_pc4_i  in  XLEN  pc, pc+4
- id_rs1_data_i, id_rs2_data_i  in  XLEN  regfile read data
- id_imm_i  in  XLEN  immediate
- id_ctrl_i  in  CTRL_W  control bundle
- id_rs1_used_i, id_rs2_used_i  in  1  source operand actually read
- id_is_load_i  in  1  instruction is a load
- wb_we_i  in  1  writeback enable
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  XLEN  writeback data
- flush_i  in  1  squash decode (taken branch/jump in EX)
- ex_ready_i  in  1  EX accepts its current instruction
- ex_valid_o  out  1  EX register holds a valid instruction
- ex_inst_o, ex_pc_o, ex_pc4_o, ex_rs1_o, ex_rs2_o, ex_imm_o  out  32/XLEN  registered payload
- ex_ctrl_o  out  CTRL_W  registered control
- ex_rd_o  out  5  registered rd
- ex_is_load_o  out  1  registered load flag
- stall_cnt_o  out  CNT_W  hazard bubbles inserted, saturating
- flush_cnt_o  out  CNT_W  flushes taken, saturating

## Operation
- advance = ~ex_valid_o | ex_ready_i. If advance=0: all registers, state, and counter hold; id_ready_o=0.
- hazard = id_valid_i & ex_valid_o & ex_is_load_o & ex_rd_o≠0 & ((id_rs1_used_i & rs1==ex_rd_o) | (id_rs2_used_i & rs2==ex_rd_o)).
- FSM states: RUN and STALL, with bubble counter bcnt.
- id_ready_o = advance & state==RUN & ~hazard & ~flush_i.
- Priority on advance: flush_i > STALL > hazard > capture > idle.
  - flush_i: bubble into EX, state→RUN, bcnt→0, flush_cnt+1.
  - STALL: bubble, bcnt−1, state→RUN when bcnt reaches 1→0, stall_cnt+1.
  - RUN & hazard: bubble, stall_cnt+1; if LOAD_STALL_CYCLES>1, bcnt←LOAD_STALL_CYCLES−1 and state→STALL.
  - RUN & id_valid_i: capture payload, ex_valid_o=1, ex_rd_o=inst[11:7].
  - Otherwise: bubble.
- Bubble: ex_valid_o=0; ctrl, inst, rd, and is_load cleared to 0. The other payload registers are don't-care and are also cleared to 0.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset: every output register is 0, state=RUN, bcnt=0. After reset, id_ready_o=1 when id_valid_i has no hazard and flush_i=0.
- Latency: 1 cycle from accepted decode to ex_*_o.
- Handshake: a transfer occurs on a rising edge with id_valid_i & id_ready_o. Decode must hold its inputs while id_ready_o=0.
- flush_i and hazard in the same cycle: flush wins, and only flush_cnt increments.
- flush_i while advance=0: the EX-held instruction is not squashed (upstream owns EX flush). The decode flush is applied on the first advance cycle only if flush_i is still asserted.
- rst_i mid-STALL: returns immediately to RUN with an empty EX.

## Configuration
- WB_BYPASS_EN defined: on capture, if wb_we_i & wb_rd_i≠0 & wb_rd_i==rs1, ex_rs1_o←wb_data_i; the same rule applies to rs2. This is for a regfile with write-after-read ordering.
- WB_BYPASS_EN undefined: operands are captured from id_rs*_data_i unchanged, and wb_* ports are unused.

## Structure
- id_ex_pkg: state enum (ST_RUN, ST_STALL), instruction field constants (RD_MSB/LSB, RS1_MSB/LSB, RS2_MSB/LSB), and a bubble constant for the control bundle.
- One sub-module: id_ex_hazard_det. It is the combinational load-use compare producing hazard, and is reusable by a future forwarding unit.

## Test plan
- Reset mid-stream: assert rst_i during a transfer → all ex_*_o=0, id_ready_o=1 the next cycle.
- Load-use: EX holds lw x5; decode add x6,x5,x1 → one bubble (ex_valid_o=0), stall_cnt=1, the add enters EX one cycle later. With LOAD_STALL_CYCLES=3 → three bubbles, stall_cnt=3.
- No false hazard: lw x0 followed by a consumer of x0, or a consumer with rs2_used=0 and a matching rs2 → no bubble.
- Backpressure: ex_ready_i=0 for 4 cycles with EX valid → ex_*_o stable, id_ready_o=0, counters unchanged.
- Flush during STALL: flush_i asserted → bubble, state RUN, flush_cnt=1, stall_cnt unchanged.
- Bypass: wb_we_i=1, wb_rd_i=7, wb_data_i=0xDEADBEEF, decoded rs1=7 with stale regfile data → ex_rs1_o=0xDEADBEEF with WB_BYPASS_EN, stale value without it. Counter saturation is checked with CNT_W=2: the fifth hazard leaves stall_cnt=3.
